writeback_register_file: RTL and testbench

- Write-back end of the MEM/WB pipeline register.
- Consumes the W-stage signals and forms ResultW, selecting load data or ALU output. It also holds the 32x32 architectural register file.
- Serves the two decode-stage read ports, with write-through bypass.
- Keeps a per-register pending-write scoreboard. Decode stalls on any source register that still has a write in flight.

---
 rtl/writeback_register_file.sv | 71 +++++++
 tb/tb_writeback_register_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// Write-back stage: result select, 32-entry register file with write-through
// read ports, and a per-register pending-write scoreboard that drives decode stall.
module writeback_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PEND_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] ALUOutW,
  input  logic [ADDR_WIDTH-1:0] WriteRegW,
  output logic [DATA_WIDTH-1:0] ResultW,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic                  IssueFull,
  output logic                  StallD,
  output logic                  ScoreErr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0][PEND_WIDTH-1:0] cnt;
  logic dec, inc, pend1, pend2;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
  assign dec     = RegWriteW && (WriteRegW != '0);

  always_comb begin
    RD1 = regs[A1];
    if (A1 == '0)                       RD1 = '0;
    else if (RegWriteW && WriteRegW == A1) RD1 = ResultW;
    RD2 = regs[A2];
    if (A2 == '0)                       RD2 = '0;
    else if (RegWriteW && WriteRegW == A2) RD2 = ResultW;
  end

  // A last outstanding write retiring this cycle is covered by the bypass.
  assign pend1 = (cnt[A1] != '0) && !(cnt[A1] == PEND_ONE && dec && WriteRegW == A1);
  assign pend2 = (cnt[A2] != '0) && !(cnt[A2] == PEND_ONE && dec && WriteRegW == A2);
  assign StallD    = ((A1 != '0) && pend1) || ((A2 != '0) && pend2);
  assign IssueFull = (cnt[IssueReg] == PEND_MAX) && (IssueReg != '0);
  assign inc       = IssueValid && !StallD && !IssueFull && (IssueReg != '0);

  // Entry 0 of regs/cnt is only ever written by reset, so it reads as zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs     <= '0;
      cnt      <= '0;
      ScoreErr <= 1'b0;
    end else begin
      if (dec) regs[WriteRegW] <= ResultW;
      if (dec && cnt[WriteRegW] == '0) ScoreErr <= 1'b1;
      for (int r = 1; r < DEPTH; r++) begin
        if (inc && IssueReg == ADDR_WIDTH'(r) && !(dec && WriteRegW == ADDR_WIDTH'(r)))
          cnt[r] <= cnt[r] + PEND_ONE;
        else if (dec && WriteRegW == ADDR_WIDTH'(r) && !(inc && IssueReg == ADDR_WIDTH'(r))
                 && cnt[r] != '0)
          cnt[r] <= cnt[r] - PEND_ONE;
      end
    end
  end
endmodule

// File: tb/tb_writeback_register_file.sv
// Bench for writeback_register_file: directed scenarios plus random traffic
// against an array-based model of the register file and pending counts.
module tb_writeback_register_file;
  logic        CLK = 1'b0;
  logic        RST, RegWriteW, MemtoRegW, IssueValid;
  logic [31:0] ReadDataW, ALUOutW, ResultW, RD1, RD2;
  logic [4:0]  WriteRegW, A1, A2, IssueReg;
  logic        IssueFull, StallD, ScoreErr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mregs [32];
  int          mcnt  [32];
  bit          merr;

  writeback_register_file dut (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .IssueValid(IssueValid), .IssueReg(IssueReg), .IssueFull(IssueFull),
    .StallD(StallD), .ScoreErr(ScoreErr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] m_res();
    return MemtoRegW ? ReadDataW : ALUOutW;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWriteW && WriteRegW == a) return m_res();
    return mregs[a];
  endfunction

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (mcnt[a] == 1 && RegWriteW && WriteRegW == a) return 1'b0;
    return mcnt[a] != 0;
  endfunction

  function automatic bit m_stall();
    return m_pend(A1) || m_pend(A2);
  endfunction

  function automatic bit m_full();
    return IssueReg != 0 && mcnt[IssueReg] == 3;
  endfunction

  // Advance one clock, applying the reference rules to the current inputs.
  task automatic tick();
    logic [31:0] nregs [32];
    int          ncnt  [32];
    bit          nerr, inc, dec;
    nregs = mregs; ncnt = mcnt; nerr = merr;
    if (RST) begin
      for (int i = 0; i < 32; i++) begin nregs[i] = 0; ncnt[i] = 0; end
      nerr = 0;
    end else begin
      dec = RegWriteW && WriteRegW != 0;
      inc = IssueValid && !m_stall() && !m_full() && IssueReg != 0;
      if (dec) nregs[WriteRegW] = m_res();
      if (dec && mcnt[WriteRegW] == 0) nerr = 1;
      if (!(inc && dec && IssueReg == WriteRegW)) begin
        if (inc) ncnt[IssueReg] = ncnt[IssueReg] + 1;
        if (dec && ncnt[WriteRegW] > 0) ncnt[WriteRegW] = ncnt[WriteRegW] - 1;
      end
    end
    @(posedge CLK);
    mregs = nregs; mcnt = ncnt; merr = nerr;
    #1;
  endtask

  task automatic idle();
    RST = 0; RegWriteW = 0; MemtoRegW = 0; ReadDataW = 0; ALUOutW = 0;
    WriteRegW = 0; A1 = 0; A2 = 0; IssueValid = 0; IssueReg = 0;
  endtask

  task automatic do_reset();
    idle(); RST = 1; tick(); RST = 0; #1;
  endtask

  task automatic test_reset();
    idle(); RST = 1; RegWriteW = 1; WriteRegW = 5; ALUOutW = 32'hAAAA_5555;
    tick(); tick();
    idle(); A1 = 5; #1;
    n_tests++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h want 0", RD1); end
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", StallD); end
    n_tests++; if (ScoreErr !== 1'b0) begin n_fail++; $display("FAIL reset_scoreerr got %b want 0", ScoreErr); end
  endtask

  task automatic test_write_bypass();
    do_reset();
    RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'h1234; ReadDataW = 32'h9999; WriteRegW = 8; A1 = 8; #1;
    n_tests++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL bypass_alu got %h want 1234", RD1); end
    tick(); RegWriteW = 0; #1;
    n_tests++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL stored_alu got %h want 1234", RD1); end
    RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'hDEAD; ALUOutW = 32'h7777; #1;
    n_tests++; if (ResultW !== 32'hDEAD) begin n_fail++; $display("FAIL result_mem got %h want dead", ResultW); end
    n_tests++; if (RD1 !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_mem got %h want dead", RD1); end
    tick(); RegWriteW = 0; MemtoRegW = 0; #1;
    n_tests++; if (RD1 !== 32'hDEAD) begin n_fail++; $display("FAIL stored_mem got %h want dead", RD1); end
  endtask

  task automatic test_reg0();
    do_reset();
    RegWriteW = 1; ALUOutW = 32'hFFFF_FFFF; WriteRegW = 0; A1 = 0; #1;
    n_tests++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reg0_bypass got %h want 0", RD1); end
    tick(); RegWriteW = 0; IssueValid = 1; IssueReg = 0; #1;
    n_tests++; if (IssueFull !== 1'b0) begin n_fail++; $display("FAIL reg0_full got %b want 0", IssueFull); end
    tick(); tick(); tick(); tick(); IssueValid = 0; #1;
    n_tests++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reg0_read got %h want 0", RD1); end
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL reg0_stall got %b want 0", StallD); end
    n_tests++; if (ScoreErr !== 1'b0) begin n_fail++; $display("FAIL reg0_scoreerr got %b want 0", ScoreErr); end
  endtask

  task automatic test_stall();
    do_reset();
    IssueValid = 1; IssueReg = 9; tick();
    IssueValid = 0; A2 = 9; #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL stall_pending got %b want 1", StallD); end
    RegWriteW = 1; WriteRegW = 9; ALUOutW = 32'h5555_AAAA; #1;
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL stall_retire got %b want 0", StallD); end
    n_tests++; if (RD2 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL stall_rd2 got %h want 5555aaaa", RD2); end
    tick(); RegWriteW = 0; #1;
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL stall_cleared got %b want 0", StallD); end
    n_tests++; if (ScoreErr !== 1'b0) begin n_fail++; $display("FAIL stall_scoreerr got %b want 0", ScoreErr); end
  endtask

  task automatic test_saturation();
    do_reset();
    IssueValid = 1; IssueReg = 3; tick(); tick();
    RegWriteW = 1; WriteRegW = 3; tick();   // same-register issue and retire: count holds at 2
    RegWriteW = 0; #1;
    n_tests++; if (IssueFull !== 1'b0) begin n_fail++; $display("FAIL sat_two got %b want 0", IssueFull); end
    tick(); #1;
    n_tests++; if (IssueFull !== 1'b1) begin n_fail++; $display("FAIL sat_full got %b want 1", IssueFull); end
    tick(); #1;
    n_tests++; if (IssueFull !== 1'b1) begin n_fail++; $display("FAIL sat_refused got %b want 1", IssueFull); end
    IssueValid = 0; RegWriteW = 1; WriteRegW = 3; tick();
    RegWriteW = 0; #1;
    n_tests++; if (IssueFull !== 1'b0) begin n_fail++; $display("FAIL sat_dec1 got %b want 0", IssueFull); end
    RegWriteW = 1; tick(); RegWriteW = 0; A1 = 3; #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL sat_one_left got %b want 1", StallD); end
    RegWriteW = 1; tick(); RegWriteW = 0; #1;
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL sat_zero got %b want 0", StallD); end
    n_tests++; if (ScoreErr !== 1'b0) begin n_fail++; $display("FAIL sat_scoreerr got %b want 0", ScoreErr); end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    RegWriteW = 1; WriteRegW = 4; tick(); RegWriteW = 0; #1;
    n_tests++; if (ScoreErr !== 1'b1) begin n_fail++; $display("FAIL underflow_set got %b want 1", ScoreErr); end
    tick(); tick(); #1;
    n_tests++; if (ScoreErr !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b want 1", ScoreErr); end
    IssueValid = 1; IssueReg = 2; tick(); IssueReg = 7; tick(); IssueValid = 0;
    A1 = 2; A2 = 0; #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL midreset_pend2 got %b want 1", StallD); end
    A1 = 0; A2 = 7; #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL midreset_pend7 got %b want 1", StallD); end
    RST = 1; tick(); RST = 0; A1 = 2; A2 = 7; #1;
    n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL midreset_stall got %b want 0", StallD); end
    n_tests++; if (ScoreErr !== 1'b0) begin n_fail++; $display("FAIL midreset_scoreerr got %b want 0", ScoreErr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      RST        = ($urandom_range(0, 199) == 0);
      RegWriteW  = ($urandom_range(0, 9) < 4);
      MemtoRegW  = $urandom_range(0, 1);
      ReadDataW  = $urandom;
      ALUOutW    = $urandom;
      WriteRegW  = 5'($urandom_range(0, 7));
      A1         = 5'($urandom_range(0, 7));
      A2         = 5'($urandom_range(0, 7));
      IssueValid = ($urandom_range(0, 9) < 5);
      IssueReg   = 5'($urandom_range(0, 7));
      #1;
      n_tests++; if (ResultW !== m_res()) begin n_fail++; $display("FAIL rnd_result c=%0d got %h want %h", c, ResultW, m_res()); end
      n_tests++; if (RD1 !== m_rd(A1)) begin n_fail++; $display("FAIL rnd_rd1 c=%0d got %h want %h", c, RD1, m_rd(A1)); end
      n_tests++; if (RD2 !== m_rd(A2)) begin n_fail++; $display("FAIL rnd_rd2 c=%0d got %h want %h", c, RD2, m_rd(A2)); end
      n_tests++; if (StallD !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d got %b want %b", c, StallD, m_stall()); end
      n_tests++; if (IssueFull !== m_full()) begin n_fail++; $display("FAIL rnd_full c=%0d got %b want %b", c, IssueFull, m_full()); end
      n_tests++; if (ScoreErr !== merr) begin n_fail++; $display("FAIL rnd_scoreerr c=%0d got %b want %b", c, ScoreErr, merr); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mregs[i] = 0; mcnt[i] = 0; end
    merr = 0;
    idle();
    #2;
    test_reset();
    test_write_bypass();
    test_reg0();
    test_stall();
    test_saturation();
    test_underflow_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
